id_stage: RTL and testbench
===========================

// Module: id_stage
// PURPOSE
//  RV32I decode stage: sits between IF/ID and the EX stage (alu_control + alu).
//  Decodes the instruction, reads the 32x32 register file and builds the immediate.
//  Detects load-use hazards and latches everything into the ID/EX register.
//  EX consumes ex_alu_op/ex_funct3/ex_funct7 directly; codes 000 = R-type, 001 = I-type ALU.
// PARAMETERS
//  XLEN        32  datapath / register width
//  REG_AW      5   register address width (2**REG_AW registers)
//  WB_BYPASS   1   1 = same-cycle writeback forwarded to ID reads; 0 = no bypass
// PORTS
//  clk           in   1     single clock, all state on posedge
//  rst           in   1     synchronous reset, active-high
//  if_valid      in   1     IF/ID holds a valid instruction
//  if_pc         in   XLEN  PC of if_instr
//  if_instr      in   32    instruction word
//  flush         in   1     taken branch/jump from EX: squash ID
//  wb_we         in   1     writeback enable
//  wb_rd         in   5     writeback destination
//  wb_data       in   XLEN  writeback value
//  stall_out     out  1     to IF: hold PC and IF/ID this cycle
//  ex_valid      out  1     ID/EX holds a real instruction
//  ex_pc         out  XLEN  latched PC
//  ex_alu_op     out  3     000 R, 001 I-ALU, 010 ld/st add, 011 branch, 100 LUI, 101 JAL/JALR/AUIPC add
//  ex_funct3     out  3     instr[14:12]
//  ex_funct7     out  7     instr[31:25]; forced 0 for I-type except SRAI (0100000)
//  ex_rs1_data   out  XLEN  rs1 operand
//  ex_rs2_data   out  XLEN  rs2 operand
//  ex_imm        out  XLEN  sign-extended immediate
//  ex_alu_src    out  1     1 = operand_b is ex_imm
//  ex_rd         out  5     destination register
//  ex_reg_write  out  1     writes rd (forced 0 when rd == 0)
//  ex_mem_read   out  1     load
//  ex_mem_write  out  1     store
//  ex_branch     out  1     conditional branch
//  ex_jump       out  1     JAL or JALR
//  ex_illegal    out  1     unrecognised opcode
// BEHAVIOUR
//  - Reset (sync): every ex_* output = 0, stall_out = 0, all 32 registers cleared to 0.
//  - Latency: 1 cycle from if_instr to ex_* outputs. Register write lands at posedge.
//  - Regfile: write when wb_we && wb_rd != 0. x0 always reads 0.
//  - Reads are combinational. With WB_BYPASS=1, wb_rd == rs (rs != 0) && wb_we returns wb_data.
//  - Imm gen: I, S, B, U, J formats per RV32I; B/J LSB = 0; U = instr[31:12] << 12.
//  - rs usage: rs1 used by all formats except U/J.
//    rs2 used only by R, S, B.
//  - Load-use hazard:
//    - Condition: ex_valid && ex_mem_read && ex_rd != 0 && ex_rd matches a used rs.
//    - Response: stall_out = 1 (combinational), ID/EX loads a bubble.
//    - The instruction re-decodes next cycle. A stall lasts exactly 1 cycle.
//  - Bubble: ex_valid = 0 and all control bits (reg_write, mem_*, branch, jump, illegal) = 0.
//    Data fields in a bubble are don't-care but driven 0.
//  - Priority: rst > flush > hazard > normal.
//    flush loads a bubble and forces stall_out = 0, even if a hazard exists.
//  - if_valid = 0 loads a bubble; no hazard is raised.
//  - Illegal opcode: ex_valid = 1, ex_illegal = 1, all other control 0.
//  - Simultaneous wb and read of the same reg: bypass governs. With no bypass, the old value is read.
// STRUCTURE
//  - Package rv_pkg: opcode localparams (OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC).
//    Also holds the ALU_OP_* 3-bit encodings shared with alu_control.
//  - Sub-module imm_gen (combinational: instr -> ex_imm + format).
//  - Regfile, hazard unit and ID/EX register stay inline.
// TESTING
//  1. 0x01400613 (ADDI x12,x0,20) -> next cycle:
//     ex_alu_op=001, funct3=000, imm=20, rd=12, alu_src=1, reg_write=1.
//  2. wb x11=8 in the same cycle as 0x00c58633 (ADD x12,x11,x12), x12=20 ->
//     ex_rs1_data=8, rs2_data=20, alu_op=000, alu_src=0.
//  3. LW x5,0(x1) then ADD x6,x5,x5 -> stall_out=1 for 1 cycle, then one bubble (ex_valid=0).
//     ADD appears the following cycle.
//  4. 0x0400006f (JAL x0,64) -> ex_jump=1, imm=64, reg_write=0.
//     Assert flush next cycle -> bubble, stall_out=0.
//  5. wb_rd=0, wb_data=0xDEADBEEF, then read x0 -> 0.
//     Opcode 0x7F -> ex_illegal=1, other control 0.
//  6. rst mid-stream after writing x3=5 -> all ex_* = 0, then read x3 -> 0.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared RV32I decode constants: opcodes, EX-stage ALU operation codes, instruction formats.
package rv_pkg;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;

  // Must stay in step with the decoding in alu_control
  localparam logic [2:0] ALU_OP_R   = 3'b000;
  localparam logic [2:0] ALU_OP_I   = 3'b001;
  localparam logic [2:0] ALU_OP_MEM = 3'b010;
  localparam logic [2:0] ALU_OP_BR  = 3'b011;
  localparam logic [2:0] ALU_OP_LUI = 3'b100;
  localparam logic [2:0] ALU_OP_ADD = 3'b101;

  typedef enum logic [2:0] {
    FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_NONE
  } fmt_e;

endpackage

// File: rtl/imm_gen.sv
// Combinational RV32I immediate generator; also reports the instruction format,
// which the decode stage uses to decide which source registers are read.
module imm_gen
  import rv_pkg::*;
(
  input  logic [31:0] instr_i,
  output logic [31:0] imm_o,
  output fmt_e        fmt_o
);

  always_comb begin
    fmt_o = FMT_NONE;
    case (instr_i[6:0])
      OP:                 fmt_o = FMT_R;
      OP_IMM, LOAD, JALR: fmt_o = FMT_I;
      STORE:              fmt_o = FMT_S;
      BRANCH:             fmt_o = FMT_B;
      LUI, AUIPC:         fmt_o = FMT_U;
      JAL:                fmt_o = FMT_J;
      default:            fmt_o = FMT_NONE;
    endcase
  end

  always_comb begin
    imm_o = '0;
    case (fmt_o)
      FMT_I: imm_o = {{20{instr_i[31]}}, instr_i[31:20]};
      FMT_S: imm_o = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      FMT_B: imm_o = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                      instr_i[11:8], 1'b0};
      FMT_U: imm_o = {instr_i[31:12], 12'b0};
      FMT_J: imm_o = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                      instr_i[30:21], 1'b0};
      default: imm_o = '0;
    endcase
  end

endmodule

// File: rtl/id_stage.sv
// RV32I decode stage: register file, control decode, load-use stall and ID/EX register.
module id_stage
  import rv_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int REG_AW    = 5,
  parameter int WB_BYPASS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_valid,
  input  logic [XLEN-1:0]   if_pc,
  input  logic [31:0]       if_instr,
  input  logic              flush,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  output logic              stall_out,
  output logic              ex_valid,
  output logic [XLEN-1:0]   ex_pc,
  output logic [2:0]        ex_alu_op,
  output logic [2:0]        ex_funct3,
  output logic [6:0]        ex_funct7,
  output logic [XLEN-1:0]   ex_rs1_data,
  output logic [XLEN-1:0]   ex_rs2_data,
  output logic [XLEN-1:0]   ex_imm,
  output logic              ex_alu_src,
  output logic [REG_AW-1:0] ex_rd,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_branch,
  output logic              ex_jump,
  output logic              ex_illegal
);

  typedef struct packed {
    logic              valid;
    logic [XLEN-1:0]   pc;
    logic [2:0]        alu_op;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic [XLEN-1:0]   rs1_data;
    logic [XLEN-1:0]   rs2_data;
    logic [XLEN-1:0]   imm;
    logic              alu_src;
    logic [REG_AW-1:0] rd;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic              branch;
    logic              jump;
    logic              illegal;
  } idex_t;

  logic [XLEN-1:0]   rf_q [2**REG_AW];
  logic [REG_AW-1:0] rs1, rs2, rd;
  logic [XLEN-1:0]   rs1_data, rs2_data;
  logic [31:0]       imm32;
  fmt_e              fmt;
  logic              rs1_used, rs2_used, load_use, take;
  logic [2:0]        alu_op;
  logic [6:0]        funct7;
  logic              alu_src, reg_write, mem_read, mem_write, branch, jump, illegal;
  idex_t             idex_d, idex_q;

  assign rs1 = if_instr[19:15];
  assign rs2 = if_instr[24:20];
  assign rd  = if_instr[11:7];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2**REG_AW; i++) rf_q[i] <= '0;
    end else if (wb_we && wb_rd != '0) begin
      rf_q[wb_rd] <= wb_data;
    end
  end

  // x0 is decoded out explicitly so a writeback aimed at x0 can never be bypassed
  assign rs1_data = (rs1 == '0) ? '0 :
                    ((WB_BYPASS != 0) && wb_we && wb_rd == rs1) ? wb_data : rf_q[rs1];
  assign rs2_data = (rs2 == '0) ? '0 :
                    ((WB_BYPASS != 0) && wb_we && wb_rd == rs2) ? wb_data : rf_q[rs2];

  imm_gen u_imm_gen (
    .instr_i (if_instr),
    .imm_o   (imm32),
    .fmt_o   (fmt)
  );

  always_comb begin
    alu_op    = ALU_OP_R;
    funct7    = if_instr[31:25];
    alu_src   = 1'b0;
    reg_write = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    branch    = 1'b0;
    jump      = 1'b0;
    illegal   = 1'b0;
    case (if_instr[6:0])
      OP: reg_write = 1'b1;
      OP_IMM: begin
        alu_op    = ALU_OP_I;
        alu_src   = 1'b1;
        reg_write = 1'b1;
        // Only SRAI keeps its funct7; other I-type immediates overlap that field
        funct7    = (if_instr[14:12] == 3'b101 && if_instr[30]) ? 7'b0100000 : 7'b0;
      end
      LOAD: begin
        alu_op    = ALU_OP_MEM;
        alu_src   = 1'b1;
        reg_write = 1'b1;
        mem_read  = 1'b1;
        funct7    = 7'b0;
      end
      STORE: begin
        alu_op    = ALU_OP_MEM;
        alu_src   = 1'b1;
        mem_write = 1'b1;
      end
      BRANCH: begin
        alu_op = ALU_OP_BR;
        branch = 1'b1;
      end
      LUI: begin
        alu_op    = ALU_OP_LUI;
        alu_src   = 1'b1;
        reg_write = 1'b1;
      end
      AUIPC: begin
        alu_op    = ALU_OP_ADD;
        alu_src   = 1'b1;
        reg_write = 1'b1;
      end
      JAL, JALR: begin
        alu_op    = ALU_OP_ADD;
        alu_src   = 1'b1;
        reg_write = 1'b1;
        jump      = 1'b1;
        if (if_instr[6:0] == JALR) funct7 = 7'b0;
      end
      default: illegal = 1'b1;
    endcase
    if (rd == '0) reg_write = 1'b0;
  end

  assign rs1_used = (fmt == FMT_R) || (fmt == FMT_I) || (fmt == FMT_S) || (fmt == FMT_B);
  assign rs2_used = (fmt == FMT_R) || (fmt == FMT_S) || (fmt == FMT_B);

  assign load_use = if_valid && idex_q.valid && idex_q.mem_read && idex_q.rd != '0 &&
                    ((rs1_used && rs1 == idex_q.rd) || (rs2_used && rs2 == idex_q.rd));
  assign stall_out = load_use && !flush && !rst;
  assign take      = if_valid && !flush && !load_use;

  always_comb begin
    idex_d = '0;
    if (take) begin
      idex_d.valid     = 1'b1;
      idex_d.pc        = if_pc;
      idex_d.alu_op    = alu_op;
      idex_d.funct3    = if_instr[14:12];
      idex_d.funct7    = funct7;
      idex_d.rs1_data  = rs1_data;
      idex_d.rs2_data  = rs2_data;
      idex_d.imm       = XLEN'($signed(imm32));
      idex_d.alu_src   = alu_src;
      idex_d.rd        = rd;
      idex_d.reg_write = reg_write;
      idex_d.mem_read  = mem_read;
      idex_d.mem_write = mem_write;
      idex_d.branch    = branch;
      idex_d.jump      = jump;
      idex_d.illegal   = illegal;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) idex_q <= '0;
    else     idex_q <= idex_d;
  end

  assign ex_valid     = idex_q.valid;
  assign ex_pc        = idex_q.pc;
  assign ex_alu_op    = idex_q.alu_op;
  assign ex_funct3    = idex_q.funct3;
  assign ex_funct7    = idex_q.funct7;
  assign ex_rs1_data  = idex_q.rs1_data;
  assign ex_rs2_data  = idex_q.rs2_data;
  assign ex_imm       = idex_q.imm;
  assign ex_alu_src   = idex_q.alu_src;
  assign ex_rd        = idex_q.rd;
  assign ex_reg_write = idex_q.reg_write;
  assign ex_mem_read  = idex_q.mem_read;
  assign ex_mem_write = idex_q.mem_write;
  assign ex_branch    = idex_q.branch;
  assign ex_jump      = idex_q.jump;
  assign ex_illegal   = idex_q.illegal;

endmodule

// File: tb/tb_id_stage.sv
// Scoreboard bench for id_stage: directed instructions with hand-decoded ID/EX contents.
module tb_id_stage;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [2:0]  alu_op;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic        alu_src;
    logic [4:0]  rd;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
    logic        jump;
    logic        illegal;
  } exp_t;

  typedef struct packed {
    logic kind;   // 0: stall_out this cycle, 1: ex_* after the next edge
    int   due;
    logic st;
    exp_t e;
  } item_t;

  localparam exp_t BUB = '0;

  logic        clk = 1'b0;
  logic        rst, if_valid, flush, wb_we;
  logic [31:0] if_pc, if_instr, wb_data;
  logic [4:0]  wb_rd;
  logic        stall_out, ex_valid, ex_alu_src, ex_reg_write, ex_mem_read;
  logic        ex_mem_write, ex_branch, ex_jump, ex_illegal;
  logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [2:0]  ex_alu_op, ex_funct3;
  logic [6:0]  ex_funct7;
  logic [4:0]  ex_rd;
  exp_t        act;

  item_t exp_q[$];
  int    cyc = 0;
  int    n_tests = 0;
  int    n_fail = 0;
  logic  done = 1'b0;
  logic  end_checked = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  id_stage #(.XLEN(32), .REG_AW(5), .WB_BYPASS(1)) dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr),
    .flush(flush), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .stall_out(stall_out), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_alu_op(ex_alu_op),
    .ex_funct3(ex_funct3), .ex_funct7(ex_funct7), .ex_rs1_data(ex_rs1_data),
    .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm), .ex_alu_src(ex_alu_src), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_branch(ex_branch), .ex_jump(ex_jump), .ex_illegal(ex_illegal)
  );

  assign act = {ex_valid, ex_pc, ex_alu_op, ex_funct3, ex_funct7, ex_rs1_data, ex_rs2_data,
                ex_imm, ex_alu_src, ex_rd, ex_reg_write, ex_mem_read, ex_mem_write,
                ex_branch, ex_jump, ex_illegal};

  function automatic exp_t ins(input logic [31:0] pc, input logic [2:0] op, input logic [2:0] f3,
                               input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] imm, input logic src, input logic [4:0] rd,
                               input logic rw, input logic mr, input logic mw, input logic br,
                               input logic jp, input logic il);
    ins = {1'b1, pc, op, f3, f7, a, b, imm, src, rd, rw, mr, mw, br, jp, il};
  endfunction

  task automatic drive(input logic r, input logic fl, input logic v, input logic [31:0] pc,
                       input logic [31:0] instr, input logic we, input logic [4:0] wrd,
                       input logic [31:0] wd, input exp_t e, input logic st);
    item_t it;
    rst = r; flush = fl; if_valid = v; if_pc = pc; if_instr = instr;
    wb_we = we; wb_rd = wrd; wb_data = wd;
    it = '{kind: 1'b0, due: cyc, st: st, e: BUB};
    exp_q.push_back(it);
    it = '{kind: 1'b1, due: cyc + 1, st: 1'b0, e: e};
    exp_q.push_back(it);
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    item_t it;
    while (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      it = exp_q.pop_front();
      n_tests++;
      if (it.kind == 1'b0) begin
        if (stall_out !== it.st) begin
          n_fail++;
          $display("FAIL stall cyc=%0d got=%b exp=%b", cyc, stall_out, it.st);
        end
      end else if (act !== it.e) begin
        n_fail++;
        $display("FAIL ex_regs cyc=%0d got=%h exp=%h", cyc, act, it.e);
      end
    end
    if (done && !end_checked) begin
      end_checked = 1'b1;
      n_tests++;
      if (exp_q.size() != 0) begin
        n_fail++;
        $display("FAIL drain got=%0d pending exp=0", exp_q.size());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; if_valid = 1'b0; if_pc = '0; if_instr = '0;
    wb_we = 1'b0; wb_rd = '0; wb_data = '0;
    @(posedge clk); #1;
    // reset state
    drive(1, 0, 0, 32'h0, 32'h0, 0, 5'd0, 32'h0, BUB, 0);
    // ADDI x12,x0,20 while x12=20 is written back
    drive(0, 0, 1, 32'h100, 32'h01400613, 1, 5'd12, 32'd20,
          ins(32'h100, 3'b001, 3'b000, 7'h00, 32'd0, 32'd0, 32'd20, 1, 5'd12, 1, 0, 0, 0, 0, 0), 0);
    // ADD x12,x11,x12 with x11=8 bypassed from writeback
    drive(0, 0, 1, 32'h104, 32'h00c58633, 1, 5'd11, 32'd8,
          ins(32'h104, 3'b000, 3'b000, 7'h00, 32'd8, 32'd20, 32'd0, 0, 5'd12, 1, 0, 0, 0, 0, 0), 0);
    // LW x5,0(x1); ADD x6,x5,x5 stalls once, then re-decodes
    drive(0, 0, 1, 32'h108, 32'h0000a283, 0, 5'd0, 32'h0,
          ins(32'h108, 3'b010, 3'b010, 7'h00, 32'd0, 32'd0, 32'd0, 1, 5'd5, 1, 1, 0, 0, 0, 0), 0);
    drive(0, 0, 1, 32'h10c, 32'h00528333, 1, 5'd5, 32'h77, BUB, 1);
    drive(0, 0, 1, 32'h10c, 32'h00528333, 0, 5'd0, 32'h0,
          ins(32'h10c, 3'b000, 3'b000, 7'h00, 32'h77, 32'h77, 32'd0, 0, 5'd6, 1, 0, 0, 0, 0, 0), 0);
    // JAL x0,64 then flush
    drive(0, 0, 1, 32'h110, 32'h0400006f, 0, 5'd0, 32'h0,
          ins(32'h110, 3'b101, 3'b000, 7'h02, 32'd0, 32'd0, 32'd64, 1, 5'd0, 0, 0, 0, 0, 1, 0), 0);
    drive(0, 1, 1, 32'h114, 32'h01400613, 0, 5'd0, 32'h0, BUB, 0);
    // flush beats a pending load-use hazard
    drive(0, 0, 1, 32'h200, 32'h0000a283, 0, 5'd0, 32'h0,
          ins(32'h200, 3'b010, 3'b010, 7'h00, 32'd0, 32'd0, 32'd0, 1, 5'd5, 1, 1, 0, 0, 0, 0), 0);
    drive(0, 1, 1, 32'h204, 32'h00528333, 0, 5'd0, 32'h0, BUB, 0);
    // if_valid=0 after a load: bubble, no hazard
    drive(0, 0, 1, 32'h208, 32'h0000a283, 0, 5'd0, 32'h0,
          ins(32'h208, 3'b010, 3'b010, 7'h00, 32'd0, 32'd0, 32'd0, 1, 5'd5, 1, 1, 0, 0, 0, 0), 0);
    drive(0, 0, 0, 32'h20c, 32'h00528333, 0, 5'd0, 32'h0, BUB, 0);
    // write to x0 is never bypassed or stored
    drive(0, 0, 1, 32'h300, 32'h000003b3, 1, 5'd0, 32'hdeadbeef,
          ins(32'h300, 3'b000, 3'b000, 7'h00, 32'd0, 32'd0, 32'd0, 0, 5'd7, 1, 0, 0, 0, 0, 0), 0);
    // ADDI x8,x0,-1: funct7 forced to 0, imm sign-extended
    drive(0, 0, 1, 32'h304, 32'hfff00413, 0, 5'd0, 32'h0,
          ins(32'h304, 3'b001, 3'b000, 7'h00, 32'd0, 32'd0, 32'hffffffff, 1, 5'd8, 1, 0, 0, 0, 0, 0), 0);
    // illegal opcode 0x7F
    drive(0, 0, 1, 32'h308, 32'h0000007f, 0, 5'd0, 32'h0,
          ins(32'h308, 3'b000, 3'b000, 7'h00, 32'd0, 32'd0, 32'd0, 0, 5'd0, 0, 0, 0, 0, 0, 1), 0);
    // SRAI x9,x12,3 keeps funct7=0100000
    drive(0, 0, 1, 32'h30c, 32'h40365493, 0, 5'd0, 32'h0,
          ins(32'h30c, 3'b001, 3'b101, 7'h20, 32'd20, 32'd0, 32'h403, 1, 5'd9, 1, 0, 0, 0, 0, 0), 0);
    // SW x12,8(x11)
    drive(0, 0, 1, 32'h310, 32'h00c5a423, 0, 5'd0, 32'h0,
          ins(32'h310, 3'b010, 3'b010, 7'h00, 32'd8, 32'd20, 32'd8, 1, 5'd8, 0, 0, 1, 0, 0, 0), 0);
    // BEQ x11,x12,-4
    drive(0, 0, 1, 32'h314, 32'hfec58ee3, 0, 5'd0, 32'h0,
          ins(32'h314, 3'b011, 3'b000, 7'h7f, 32'd8, 32'd20, 32'hfffffffc, 0, 5'd29, 0, 0, 0, 1, 0, 0), 0);
    // LUI x10,0x12345
    drive(0, 0, 1, 32'h318, 32'h12345537, 0, 5'd0, 32'h0,
          ins(32'h318, 3'b100, 3'b101, 7'h09, 32'd0, 32'd0, 32'h12345000, 1, 5'd10, 1, 0, 0, 0, 0, 0), 0);
    // x3=5, then reset mid-stream, then read x3
    drive(0, 0, 0, 32'h31c, 32'h0, 1, 5'd3, 32'd5, BUB, 0);
    drive(1, 0, 1, 32'h320, 32'h003186b3, 0, 5'd0, 32'h0, BUB, 0);
    drive(0, 0, 1, 32'h400, 32'h003186b3, 0, 5'd0, 32'h0,
          ins(32'h400, 3'b000, 3'b000, 7'h00, 32'd0, 32'd0, 32'd0, 0, 5'd13, 1, 0, 0, 0, 0, 0), 0);
    drive(0, 0, 0, 32'h0, 32'h0, 0, 5'd0, 32'h0, BUB, 0);
    done = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
